// File: rtl/adder_vector_driver_pkg.sv
// Shared constants and types for the adder vector driver: default width, LFSR taps,
// the "no failure recorded" marker and the run-control state encoding.
package adder_vector_driver_pkg;

    localparam int unsigned WIDTH_DEF = 4;

    // x^8+x^6+x^5+x^4+1: feedback taps on bits 7, 5, 4 and 3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [15:0] NO_FAIL = 16'hFFFF;
    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StDone
    } state_t;

endpackage

// File: rtl/adder_vector_driver_lfsr8.sv
// 8-bit Fibonacci LFSR, shifting left with feedback into bit 0; load takes priority over enable.
module lfsr8
    import adder_vector_driver_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (en) begin
            q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/adder_vector_driver.sv
// On-board stimulus source and checker for a 4-operand adder: walks a counter/LFSR vector
// sequence, samples sum/ov at the end of each hold window and tallies mismatches.
module adder_vector_driver
    import adder_vector_driver_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned NUM_VEC = 256,
    parameter int unsigned LAT     = 0,
    parameter int unsigned D_MODE  = 1,
    parameter logic [7:0]  SEED    = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] sum,
    input  logic             ov,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_cnt,
    output logic [15:0]      fail_idx
);

    localparam int unsigned     HCW       = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(LAT);
    localparam logic [15:0]     LAST_IDX  = 16'(NUM_VEC - 1);
    localparam logic [WIDTH-1:0] OP_MAX   = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [15:0]      vec_q, vec_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic [15:0]      err_q, err_d;
    logic [15:0]      fail_q, fail_d;

    logic       lfsr_en;
    logic       lfsr_load;
    logic [7:0] lfsr_q;
    logic       unused_lfsr_hi;

    lfsr8 #(
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (lfsr_en),
        .load (lfsr_load),
        .seed (SEED),
        .q    (lfsr_q)
    );

    assign unused_lfsr_hi = ^lfsr_q[7:4];

    // d follows the LFSR directly; outside a run (idle/reset) it reads 0
    assign d = (D_MODE != 0 && state_q != StIdle) ? WIDTH'(lfsr_q[3:0]) : '0;

    // Reference model, two guard bits so any carry out of WIDTH shows up as overflow
    logic [WIDTH+1:0] ref_s;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_ov;
    logic             mismatch;

    always_comb begin
        ref_s    = {2'b00, a_q} + {2'b00, b_q} + {2'b00, c_q} + {2'b00, d};
        exp_sum  = ref_s[WIDTH-1:0];
        exp_ov   = |ref_s[WIDTH+1:WIDTH];
        mismatch = (sum != exp_sum) || (ov != exp_ov);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        vec_d     = vec_q;
        hold_d    = hold_q;
        err_d     = err_q;
        fail_d    = fail_q;
        lfsr_en   = 1'b0;
        lfsr_load = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StHold;
                    a_d       = '0;
                    b_d       = '0;
                    c_d       = '0;
                    vec_d     = '0;
                    hold_d    = '0;
                    err_d     = '0;
                    fail_d    = NO_FAIL;
                    lfsr_load = 1'b1;
                end
            end
            StHold: begin
                if (hold_q == HOLD_LAST) begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 16'd1;
                        end
                        if (fail_q == NO_FAIL) begin
                            fail_d = vec_q;
                        end
                    end
                    if (vec_q == LAST_IDX) begin
                        state_d = StDone;
                    end else begin
                        hold_d  = '0;
                        vec_d   = vec_q + 16'd1;
                        a_d     = a_q + 1'b1;
                        lfsr_en = 1'b1;
                        if (a_q == OP_MAX) begin
                            b_d = b_q + 1'b1;
                            if (b_q == OP_MAX) begin
                                c_d = c_q + 1'b1;
                            end
                        end
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            vec_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            fail_q  <= NO_FAIL;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign c        = c_q;
    assign busy     = (state_q == StHold);
    assign done     = (state_q == StDone);
    assign pass     = done && (err_q == 16'd0);
    assign err_cnt  = err_q;
    assign fail_idx = fail_q;

endmodule

// File: tb/tb_adder_vector_driver.sv
// Directed bench: three driver instances around a behavioural adder with injectable faults.
module tb_adder_vector_driver;

    logic clk;
    logic rst;
    int   fault;
    int   errors;
    int   checks;

    logic start0, start1, start2;

    logic [3:0]  a0, b0, c0, d0, sum0;
    logic        ov0, busy0, done0, pass0;
    logic [15:0] err0, fail0;

    logic [3:0]  a1, b1, c1, d1, sum1;
    logic        ov1, busy1, done1, pass1;
    logic [15:0] err1, fail1;

    logic [3:0]  a2, b2, c2, d2, sum2;
    logic        ov2, busy2, done2, pass2;
    logic [15:0] err2, fail2;

    logic [7:0] lf;
    logic [3:0] rec_d [16];

    // fm: 0 = correct, 1 = ov stuck at 0, 2 = sum[0] stuck at 0
    function automatic logic [4:0] adder_model(input logic [3:0] x, input logic [3:0] y,
                                               input logic [3:0] z, input logic [3:0] w,
                                               input int fm);
        logic [5:0] s;
        logic [4:0] r;
        s = {2'b00, x} + {2'b00, y} + {2'b00, z} + {2'b00, w};
        r = {|s[5:4], s[3:0]};
        if (fm == 1) r[4] = 1'b0;
        if (fm == 2) r[0] = 1'b0;
        return r;
    endfunction

    assign {ov0, sum0} = adder_model(a0, b0, c0, d0, fault);
    assign {ov1, sum1} = adder_model(a1, b1, c1, d1, fault);
    assign {ov2, sum2} = adder_model(a2, b2, c2, d2, fault);

    adder_vector_driver #(.WIDTH(4), .NUM_VEC(256), .LAT(0), .D_MODE(0), .SEED(8'hA5)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .c(c0), .d(d0),
        .sum(sum0), .ov(ov0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_idx(fail0)
    );

    adder_vector_driver #(.WIDTH(4), .NUM_VEC(16), .LAT(0), .D_MODE(0), .SEED(8'hA5)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .d(d1),
        .sum(sum1), .ov(ov1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_idx(fail1)
    );

    adder_vector_driver #(.WIDTH(4), .NUM_VEC(16), .LAT(2), .D_MODE(1), .SEED(8'hA5)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c(c2), .d(d2),
        .sum(sum2), .ov(ov2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_idx(fail2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Walks one LAT=2 run of dut2 from the start edge, checking each vector is held 3 cycles
    task automatic run_dut2(input bit compare_rec);
        lf = 8'hA5;
        for (int k = 0; k < 16; k++) begin
            if (!compare_rec) rec_d[k] = d2;
            for (int h = 0; h < 3; h++) begin
                check("hold_a", {28'd0, a2}, k);
                check("hold_d_lfsr", {28'd0, d2}, {28'd0, lf[3:0]});
                if (compare_rec) check("rerun_d", {28'd0, d2}, {28'd0, rec_d[k]});
                check("hold_busy", {31'd0, busy2}, 1);
                step();
            end
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        end
        check("lat2_done", {31'd0, done2}, 1);
        check("lat2_pass", {31'd0, pass2}, 1);
        check("lat2_err", {16'd0, err2}, 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        fault  = 0;
        rst    = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        step();
        step();
        rst = 1'b1;

        check("rst_a", {28'd0, a0}, 0);
        check("rst_busy", {31'd0, busy0}, 0);
        check("rst_done", {31'd0, done0}, 0);
        check("rst_pass", {31'd0, pass0}, 0);
        check("rst_err", {16'd0, err0}, 0);
        check("rst_fail", {16'd0, fail0}, 32'h0000FFFF);
        check("rst_d_dmode1", {28'd0, d2}, 0);

        repeat (3) step();

        // Clean 256-vector run with a start pulse at vector 10 that must be ignored
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            check("run_busy", {31'd0, busy0}, 1);
            check("run_not_done", {31'd0, done0}, 0);
            if (i == 10) start0 = 1'b1;
            step();
            start0 = 1'b0;
        end
        check("clean_done", {31'd0, done0}, 1);
        check("clean_busy", {31'd0, busy0}, 0);
        check("clean_pass", {31'd0, pass0}, 1);
        check("clean_err", {16'd0, err0}, 0);
        check("clean_fail", {16'd0, fail0}, 32'h0000FFFF);
        check("clean_last_a", {28'd0, a0}, 15);
        check("clean_last_b", {28'd0, b0}, 15);
        check("clean_last_c", {28'd0, c0}, 0);
        check("clean_d_zero", {28'd0, d0}, 0);

        // ov stuck at 0: 120 overflowing vectors, first at b=1 a=15
        fault  = 1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (256) step();
        check("ovstuck_done", {31'd0, done0}, 1);
        check("ovstuck_err", {16'd0, err0}, 120);
        check("ovstuck_fail", {16'd0, fail0}, 31);
        check("ovstuck_pass", {31'd0, pass0}, 0);

        // sum[0] stuck at 0 on 16 vectors: every odd a mismatches
        fault  = 2;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (16) step();
        check("s0stuck_done", {31'd0, done1}, 1);
        check("s0stuck_err", {16'd0, err1}, 8);
        check("s0stuck_fail", {16'd0, fail1}, 1);
        check("s0stuck_pass", {31'd0, pass1}, 0);

        // LAT=2 with LFSR-driven d, then restart from DONE and expect the same sequence
        fault  = 0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        run_dut2(1'b0);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        run_dut2(1'b1);

        // Reset mid-run at vector 100 with errors already counted
        fault  = 1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (100) step();
        check("pre_rst_err", {16'd0, err0}, 15);
        check("pre_rst_a", {28'd0, a0}, 4);
        check("pre_rst_b", {28'd0, b0}, 6);
        check("pre_rst_busy", {31'd0, busy0}, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_a", {28'd0, a0}, 0);
        check("mid_rst_b", {28'd0, b0}, 0);
        check("mid_rst_busy", {31'd0, busy0}, 0);
        check("mid_rst_done", {31'd0, done0}, 0);
        check("mid_rst_err", {16'd0, err0}, 0);
        check("mid_rst_fail", {16'd0, fail0}, 32'h0000FFFF);
        check("mid_rst_d2", {28'd0, d2}, 0);
        check("mid_rst_done2", {31'd0, done2}, 0);
        step();
        rst   = 1'b1;
        fault = 0;
        step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (255) step();
        check("post_rst_not_done", {31'd0, done0}, 0);
        step();
        check("post_rst_done", {31'd0, done0}, 1);
        check("post_rst_pass", {31'd0, pass0}, 1);
        check("post_rst_err", {16'd0, err0}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_vector_driver.md
Name: adder_vector_driver

Overview:
- Synthesizable, self-checking stimulus source for the 4-operand adder (a+b+c+d -> sum, ov).
- Generates operand vectors from counters and an LFSR, drives them into the adder, and samples sum/ov after a fixed hold window.
- Compares the samples against an internal reference model and reports pass/fail, error count and the first failing vector index.
- Sits beside the adder in the lab top level, in place of a simulation-only bench, so the same check can run on the board.

Parameters:
- WIDTH, 4: operand and sum width.
- NUM_VEC, 256: number of vectors per run (1..65535).
- LAT, 0: extra hold cycles before sampling; the hold window is LAT+1 cycles.
- D_MODE, 1: 0 = d held at 0; 1 = d = lfsr[3:0].
- SEED, 8'hA5: LFSR reset/restart value; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse, begins a run
- a  out  WIDTH  operand a to adder
- b  out  WIDTH  operand b
- c  out  WIDTH  operand c
- d  out  WIDTH  operand d
- sum  in  WIDTH  adder sum
- ov  in  1  adder overflow
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  valid when done; 1 iff err_cnt==0
- err_cnt  out  16  mismatching vectors, saturates at 16'hFFFF
- fail_idx  out  16  index of first mismatch; 16'hFFFF if none

Behaviour:
- Interface: reset rst, asynchronous, active-low; clock clk.
- Reset values: a=b=c=d=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=16'hFFFF, FSM=IDLE, lfsr=SEED, vec_idx=0, hold_cnt=0.
- Reset asserted mid-run aborts the run immediately and returns everything to reset values. No partial results are kept.
- Reference model: s = a+b+c+d evaluated at WIDTH+2 bits. exp_sum = s[WIDTH-1:0]. exp_ov = (s > 2^WIDTH-1).
- FSM states: IDLE, HOLD, DONE.
- IDLE:
  - start=1: load a=b=c=0, d=(D_MODE ? SEED[3:0] : 0), vec_idx=0, hold_cnt=0, err_cnt=0, fail_idx=FFFF, done=0, busy=1, then go to HOLD.
- HOLD: operands are stable; hold_cnt counts 0..LAT.
  - At the edge where hold_cnt==LAT, sample sum/ov and compare with the model of the current operands.
  - Mismatch when sum!=exp_sum or ov!=exp_ov. On mismatch, err_cnt increments (saturating). If fail_idx==FFFF, set fail_idx=vec_idx.
  - On that same edge, if vec_idx==NUM_VEC-1, go to DONE. Otherwise advance to the next vector and reset hold_cnt to 0.
- DONE: busy=0, done=1, pass=(err_cnt==0). Operands hold their last vector.
  - start=1 restarts exactly as from IDLE.
- Vector sequence:
  - a increments every vector, wrapping 15->0.
  - b increments when a wraps.
  - c increments when a and b both wrap.
  - The LFSR (x^8+x^6+x^5+x^4+1, Fibonacci, shifts left, feedback into bit 0) advances once per vector.
  - vec_idx = c*256 + b*16 + a while below 4096.
- start while busy is ignored.
- With LAT=0, each vector lasts one cycle, so a run takes NUM_VEC cycles from the start edge to done.

Decomposition:
- Shared package: WIDTH default, LFSR tap mask, the FFFF "no fail" constant, and the FSM state enum.
- One natural sub-module: lfsr8 (enable, load, seed -> q).
- The reference model stays inline as combinational logic.

Test Plan:
- Correct adder, NUM_VEC=256, D_MODE=0, LAT=0, start at cycle 5 -> busy for 256 cycles; done=1, pass=1, err_cnt=0, fail_idx=FFFF.
- Adder with ov stuck 0, NUM_VEC=256, D_MODE=0:
  - Overflowing vectors are those with a+b>15; there are 120 of them.
  - Required: err_cnt=120, pass=0, fail_idx=31 (b=1, a=15).
- Adder with sum[0] stuck 0, NUM_VEC=16, D_MODE=0 -> err_cnt=8, fail_idx=1.
- LAT=2, correct adder, NUM_VEC=16 -> each operand set is held exactly 3 cycles; done after 48 cycles; pass=1.
- Reset pulled low at vector 100 of a 256 run -> all outputs return to reset values on the same edge; the next start produces a full clean run with pass=1.
- start pulsed at vector 10 (ignored); then start in DONE -> a second run whose sequence is identical, including LFSR values with D_MODE=1.
